reg_scoreboard: RTL and testbench

Tracks in-flight writes to the 32 architectural registers and stalls instruction issue on read-after-write and write-after-write hazards. It sits between decode/issue, which produces 5-bit destination tags, and writeback, which retires them. It is the consumer end of the 5-bit tag latches in the pipeline: issue sets a register's busy bit and writeback clears it.

---
 rtl/reg_scoreboard_pkg.sv | 12 +
 rtl/dffe_ref.sv | 15 +
 rtl/reg_scoreboard_decoder5to32.sv | 15 +
 rtl/reg_scoreboard.sv | 83 ++++++++
 tb/tb_reg_scoreboard.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
package reg_scoreboard_pkg;

   localparam int unsigned NREGS = 32;
   localparam int unsigned TAGW  = 5;
   localparam int unsigned CNTW  = 6;

   localparam logic [TAGW-1:0] TAG_ZERO = '0;

   typedef logic [NREGS-1:0] reg_vec_t;

endpackage

// File: rtl/dffe_ref.sv
// Enable flop with asynchronous active-high clear, one per busy bit.
module dffe_ref (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr)     q <= 1'b0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/reg_scoreboard_decoder5to32.sv
// Register tag to one-hot decoder; all-zero output when disabled.
module decoder5to32
   import reg_scoreboard_pkg::*;
(
   input  logic            en,
   input  logic [TAGW-1:0] tag,
   output logic [NREGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[tag] = 1'b1;
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for the architectural registers: stalls issue on
// RAW/WAW hazards, with same-cycle writeback bypassed into the check.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             issue_valid,
   input  logic [TAGW-1:0]  issue_rd,
   input  logic [TAGW-1:0]  issue_rs1,
   input  logic [TAGW-1:0]  issue_rs2,
   input  logic             issue_use1,
   input  logic             issue_use2,
   input  logic             wb_valid,
   input  logic [TAGW-1:0]  wb_rd,
   input  logic             flush,
   output logic             stall,
   output logic             issue_accept,
   output logic [NREGS-1:0] busy_vec,
   output logic [CNTW-1:0]  outstanding,
   output logic             wb_err
);

   reg_vec_t iss_oh, wb_oh, eff_busy;
   reg_vec_t set_vec, clr_vec, busy_nxt, busy_en;
   logic     set_chg, clr_chg;
   logic     wb_err_nxt;
   logic [CNTW-1:0] cnt_nxt;

   decoder5to32 u_dec_issue (
      .en     (1'b1),
      .tag    (issue_rd),
      .onehot (iss_oh)
   );

   decoder5to32 u_dec_wb (
      .en     (wb_valid),
      .tag    (wb_rd),
      .onehot (wb_oh)
   );

   // Hazard check sees a retiring register as already free.
   always_comb begin
      eff_busy     = busy_vec & ~wb_oh;
      stall        = issue_valid & ((issue_use1 & eff_busy[issue_rs1]) |
                                    (issue_use2 & eff_busy[issue_rs2]) |
                                    eff_busy[issue_rd]);
      issue_accept = issue_valid & ~stall & ~flush;
   end

   // Set beats clear on the same tag; register 0 is never set.
   always_comb begin
      set_vec    = (issue_accept && issue_rd != TAG_ZERO) ? iss_oh : '0;
      clr_vec    = wb_oh & busy_vec;
      busy_nxt   = flush ? '0 : (set_vec | (busy_vec & ~clr_vec));
      busy_en    = busy_nxt ^ busy_vec;
      set_chg    = |(set_vec & ~busy_vec);
      clr_chg    = |(clr_vec & ~set_vec);
      cnt_nxt    = flush ? '0 : CNTW'(outstanding + CNTW'(set_chg) - CNTW'(clr_chg));
      wb_err_nxt = wb_err | (~flush & wb_valid & ~busy_vec[wb_rd] & (wb_rd != TAG_ZERO));
   end

   for (genvar g = 0; g < int'(NREGS); g++) begin : g_busy
      dffe_ref u_bit (
         .clk (clk),
         .clr (clr),
         .en  (busy_en[g]),
         .d   (busy_nxt[g]),
         .q   (busy_vec[g])
      );
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         outstanding <= '0;
         wb_err      <= 1'b0;
      end else begin
         outstanding <= cnt_nxt;
         wb_err      <= wb_err_nxt;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random
// traffic against a per-register busy model.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   logic             clk = 1'b0;
   logic             clr;
   logic             issue_valid, issue_use1, issue_use2;
   logic [TAGW-1:0]  issue_rd, issue_rs1, issue_rs2;
   logic             wb_valid;
   logic [TAGW-1:0]  wb_rd;
   logic             flush;
   logic             stall, issue_accept;
   logic [NREGS-1:0] busy_vec;
   logic [CNTW-1:0]  outstanding;
   logic             wb_err;

   int checks   = 0;
   int failures = 0;

   bit m_busy [NREGS];
   int m_cnt;
   bit m_err;

   reg_scoreboard dut (
      .clk          (clk),
      .clr          (clr),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_rs1    (issue_rs1),
      .issue_rs2    (issue_rs2),
      .issue_use1   (issue_use1),
      .issue_use2   (issue_use2),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .flush        (flush),
      .stall        (stall),
      .issue_accept (issue_accept),
      .busy_vec     (busy_vec),
      .outstanding  (outstanding),
      .wb_err       (wb_err)
   );

   always #5 clk = ~clk;

   // Reference model: a register is a hazard if busy and not retiring now.
   function automatic bit m_hazard(input int t);
      return t != 0 && m_busy[t] && !(wb_valid && int'(wb_rd) == t);
   endfunction

   function automatic bit m_stall();
      return issue_valid && ((issue_use1 && m_hazard(int'(issue_rs1))) ||
                             (issue_use2 && m_hazard(int'(issue_rs2))) ||
                             m_hazard(int'(issue_rd)));
   endfunction

   function automatic bit m_accept();
      return issue_valid && !m_stall() && !flush;
   endfunction

   function automatic logic [NREGS-1:0] m_vec();
      logic [NREGS-1:0] v;
      for (int i = 0; i < int'(NREGS); i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(NREGS); i++) m_busy[i] = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_clock();
      bit acc;
      int w, d;
      acc = m_accept();
      w   = int'(wb_rd);
      d   = int'(issue_rd);
      if (flush) begin
         for (int i = 0; i < int'(NREGS); i++) m_busy[i] = 1'b0;
         m_cnt = 0;
      end else begin
         if (wb_valid && w != 0) begin
            if (m_busy[w]) begin
               m_busy[w] = 1'b0;
               m_cnt--;
            end else begin
               m_err = 1'b1;
            end
         end
         if (acc && d != 0 && !m_busy[d]) begin
            m_busy[d] = 1'b1;
            m_cnt++;
         end
      end
   endtask

   task automatic idle();
      issue_valid = 0; issue_use1 = 0; issue_use2 = 0;
      issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
      wb_valid = 0; wb_rd = '0; flush = 0;
   endtask

   task automatic drive_issue(input int rd, input int rs1, input bit u1,
                              input int rs2, input bit u2);
      issue_valid = 1;
      issue_rd  = TAGW'(rd);
      issue_rs1 = TAGW'(rs1); issue_use1 = u1;
      issue_rs2 = TAGW'(rs2); issue_use2 = u2;
   endtask

   task automatic drive_wb(input int rd);
      wb_valid = 1;
      wb_rd    = TAGW'(rd);
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (busy_vec !== '0 || outstanding !== '0 || wb_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_init busy=%h out=%0d err=%b want 0/0/0", busy_vec, outstanding, wb_err);
      end
      @(negedge clk); idle(); drive_issue(4, 0, 0, 0, 0);
      tick();
      @(negedge clk); idle(); drive_wb(9);
      tick();
      checks++;
      if (busy_vec !== 32'h0000_0010 || wb_err !== 1'b1) begin
         failures++;
         $display("FAIL reset_pre busy=%h err=%b want 00000010/1", busy_vec, wb_err);
      end
      @(negedge clk); idle();
      #2 clr = 1; model_reset();
      #1;
      checks++;
      if (busy_vec !== '0 || outstanding !== '0 || wb_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_async busy=%h out=%0d err=%b want 0/0/0", busy_vec, outstanding, wb_err);
      end
      @(negedge clk); clr = 0;
   endtask

   task automatic test_raw();
      @(negedge clk); idle(); drive_issue(5, 0, 0, 0, 0);
      #1;
      checks++;
      if (issue_accept !== 1'b1 || stall !== 1'b0) begin
         failures++;
         $display("FAIL raw_first acc=%b stall=%b want 1/0", issue_accept, stall);
      end
      tick();
      @(negedge clk); idle(); drive_issue(0, 5, 1, 0, 0);
      #1;
      checks++;
      if (stall !== 1'b1 || issue_accept !== 1'b0) begin
         failures++;
         $display("FAIL raw_stall stall=%b acc=%b want 1/0", stall, issue_accept);
      end
      drive_wb(5);
      #1;
      checks++;
      if (stall !== 1'b0 || issue_accept !== 1'b1) begin
         failures++;
         $display("FAIL raw_bypass stall=%b acc=%b want 0/1", stall, issue_accept);
      end
      tick();
      checks++;
      if (busy_vec !== '0 || outstanding !== 6'd0) begin
         failures++;
         $display("FAIL raw_retire busy=%h out=%0d want 0/0", busy_vec, outstanding);
      end
   endtask

   task automatic test_waw();
      @(negedge clk); idle(); drive_issue(7, 0, 0, 0, 0);
      tick();
      @(negedge clk); idle(); drive_issue(7, 0, 0, 0, 0); drive_wb(7);
      #1;
      checks++;
      if (issue_accept !== 1'b1) begin
         failures++;
         $display("FAIL waw_accept acc=%b want 1", issue_accept);
      end
      tick();
      checks++;
      if (busy_vec !== 32'h0000_0080 || outstanding !== 6'd1 || wb_err !== 1'b0) begin
         failures++;
         $display("FAIL waw_setwins busy=%h out=%0d err=%b want 00000080/1/0", busy_vec, outstanding, wb_err);
      end
      @(negedge clk); idle(); drive_wb(7);
      tick();
   endtask

   task automatic test_tag_zero();
      @(negedge clk); idle(); drive_issue(0, 0, 1, 0, 1); drive_wb(0);
      #1;
      checks++;
      if (stall !== 1'b0 || issue_accept !== 1'b1) begin
         failures++;
         $display("FAIL tag0_comb stall=%b acc=%b want 0/1", stall, issue_accept);
      end
      tick();
      checks++;
      if (busy_vec !== '0 || outstanding !== 6'd0 || wb_err !== 1'b0) begin
         failures++;
         $display("FAIL tag0_state busy=%h out=%0d err=%b want 0/0/0", busy_vec, outstanding, wb_err);
      end
   endtask

   task automatic test_flush();
      @(negedge clk); idle(); drive_issue(3, 0, 0, 0, 0);
      tick();
      @(negedge clk); idle(); drive_issue(9, 0, 0, 0, 0);
      tick();
      checks++;
      if (busy_vec !== 32'h0000_0208 || outstanding !== 6'd2) begin
         failures++;
         $display("FAIL flush_pre busy=%h out=%0d want 00000208/2", busy_vec, outstanding);
      end
      @(negedge clk); idle(); drive_issue(4, 0, 0, 0, 0); drive_wb(3); flush = 1;
      #1;
      checks++;
      if (issue_accept !== 1'b0) begin
         failures++;
         $display("FAIL flush_accept acc=%b want 0", issue_accept);
      end
      tick();
      checks++;
      if (busy_vec !== '0 || outstanding !== 6'd0 || wb_err !== 1'b0) begin
         failures++;
         $display("FAIL flush_state busy=%h out=%0d err=%b want 0/0/0", busy_vec, outstanding, wb_err);
      end
      @(negedge clk); idle(); drive_wb(9);
      tick();
      checks++;
      if (wb_err !== 1'b1) begin
         failures++;
         $display("FAIL flush_late_wb err=%b want 1", wb_err);
      end
   endtask

   task automatic test_back_to_back();
      int acc_miss = 0;
      for (int i = 1; i < int'(NREGS); i++) begin
         @(negedge clk); idle(); drive_issue(i, 0, 0, 0, 0);
         #1;
         if (issue_accept !== 1'b1) acc_miss++;
         tick();
      end
      checks++;
      if (acc_miss != 0) begin
         failures++;
         $display("FAIL fill_accept missed=%0d want 0", acc_miss);
      end
      checks++;
      if (busy_vec !== 32'hFFFF_FFFE || outstanding !== 6'd31) begin
         failures++;
         $display("FAIL fill_full busy=%h out=%0d want fffffffe/31", busy_vec, outstanding);
      end
      for (int i = 1; i < int'(NREGS); i++) begin
         @(negedge clk); idle(); drive_wb(i);
         tick();
      end
      checks++;
      if (busy_vec !== '0 || outstanding !== 6'd0 || wb_err !== 1'b1) begin
         failures++;
         $display("FAIL fill_drain busy=%h out=%0d err=%b want 0/0/1", busy_vec, outstanding, wb_err);
      end
   endtask

   task automatic test_random();
      int bad_comb = 0, bad_reg = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk); idle();
         if ($urandom_range(0, 3) != 0)
            drive_issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom),
                        int'($urandom_range(0, 7)), 1'($urandom));
         if ($urandom_range(0, 2) != 0) drive_wb(int'($urandom_range(0, 7)));
         flush = ($urandom_range(0, 24) == 0);
         #1;
         if (stall !== m_stall() || issue_accept !== m_accept()) begin
            bad_comb++;
            if (bad_comb <= 3)
               $display("FAIL rand_comb n=%0d stall=%b acc=%b want %b/%b",
                        n, stall, issue_accept, m_stall(), m_accept());
         end
         tick();
         if (busy_vec !== m_vec() || outstanding !== CNTW'(m_cnt) || wb_err !== m_err) begin
            bad_reg++;
            if (bad_reg <= 3)
               $display("FAIL rand_state n=%0d busy=%h out=%0d err=%b want %h/%0d/%b",
                        n, busy_vec, outstanding, wb_err, m_vec(), m_cnt, m_err);
         end
      end
      checks++;
      if (bad_comb != 0) failures++;
      checks++;
      if (bad_reg != 0) failures++;
   endtask

   initial begin
      idle();
      clr = 1;
      model_reset();
      repeat (2) @(negedge clk);
      clr = 0;
      #1;
      test_reset();
      test_raw();
      test_waw();
      test_tag_zero();
      test_flush();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
